// File: rtl/int_div_pkg.sv
// Shared types and width helpers for the sequential vector divider.
package int_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_e;

  // Remainder needs one guard bit above the wider operand so the shifted value never overflows.
  function automatic int unsigned rem_width(input int unsigned dvd_w, input int unsigned dvs_w);
    return ((dvd_w > dvs_w) ? dvd_w : dvs_w) + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_div_restoring_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract the divisor if it fits.
module int_div_restoring_step #(
  parameter int unsigned DIVISOR_WIDTH = 8,
  parameter int unsigned REM_W         = 9
) (
  input  logic [REM_W-1:0]         rem_i,
  input  logic                     dvd_bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [REM_W-1:0]         rem_o,
  output logic                     q_bit_o
);

  always_comb begin
    q_bit_o = ({rem_i, dvd_bit_i} >= (REM_W + 1)'(divisor_i));
    rem_o   = q_bit_o ? REM_W'({rem_i, dvd_bit_i} - (REM_W + 1)'(divisor_i))
                      : REM_W'({rem_i, dvd_bit_i});
  end

endmodule

// File: rtl/int_div_seq_ctrl.sv
// Sequential vector unsigned divider: PAR_LANES restoring lanes iterate over IN_NUM elements,
// one quotient bit per lane per cycle, with join handshake in and valid/ready out.
module int_div_seq_ctrl
  import int_div_pkg::*;
#(
  parameter int unsigned IN_NUM         = 8,
  parameter int unsigned DIVIDEND_WIDTH = 8,
  parameter int unsigned DIVISOR_WIDTH  = 8,
  parameter int unsigned QUOTIENT_WIDTH = 8,
  parameter int unsigned PAR_LANES      = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [IN_NUM-1:0][DIVIDEND_WIDTH-1:0]         dividend_data,
  input  logic                                          dividend_data_valid,
  output logic                                          dividend_data_ready,
  input  logic [IN_NUM-1:0][DIVISOR_WIDTH-1:0]          divisor_data,
  input  logic                                          divisor_data_valid,
  output logic                                          divisor_data_ready,
  output logic [IN_NUM-1:0][QUOTIENT_WIDTH-1:0]         quotient_data,
  output logic                                          quotient_data_valid,
  input  logic                                          quotient_data_ready,
  output logic                                          busy
);

  localparam int unsigned NUM_GROUPS = IN_NUM / PAR_LANES;
  localparam int unsigned REM_W      = rem_width(DIVIDEND_WIDTH, DIVISOR_WIDTH);
  localparam int unsigned GW         = cnt_width(NUM_GROUPS);
  localparam int unsigned BW         = cnt_width(DIVIDEND_WIDTH);
  localparam int unsigned IW         = cnt_width(IN_NUM);
  localparam logic [GW-1:0] G_LAST   = GW'(NUM_GROUPS - 1);
  localparam logic [BW-1:0] B_FIRST  = BW'(DIVIDEND_WIDTH - 1);

  if (IN_NUM % PAR_LANES != 0) begin : g_lane_check
    $error("int_div_seq_ctrl: IN_NUM must be a multiple of PAR_LANES");
  end

  state_e                                     state_q;
  logic [GW-1:0]                              g_q;
  logic [BW-1:0]                              b_q;
  logic [IN_NUM-1:0][DIVIDEND_WIDTH-1:0]      dvd_q;
  logic [IN_NUM-1:0][DIVISOR_WIDTH-1:0]       dvs_q;
  logic [PAR_LANES-1:0][REM_W-1:0]            rem_q;
  logic [PAR_LANES-1:0][DIVIDEND_WIDTH-1:0]   qacc_q;
  logic [IN_NUM-1:0][QUOTIENT_WIDTH-1:0]      quot_q;
  logic                                       valid_q;
  logic                                       busy_q;

  logic [PAR_LANES-1:0][IW-1:0]               lane_idx;
  logic [PAR_LANES-1:0]                       lane_dvd_bit;
  logic [PAR_LANES-1:0]                       lane_q;
  logic [PAR_LANES-1:0][DIVISOR_WIDTH-1:0]    lane_dvs;
  logic [PAR_LANES-1:0][REM_W-1:0]            lane_rem;
  logic [PAR_LANES-1:0][DIVIDEND_WIDTH-1:0]   lane_qfull;
  logic [PAR_LANES-1:0][QUOTIENT_WIDTH-1:0]   lane_res;

  // Each side's ready mirrors the other side's valid so neither vector is consumed alone.
  assign dividend_data_ready = rst && (state_q == IDLE) && divisor_data_valid;
  assign divisor_data_ready  = rst && (state_q == IDLE) && dividend_data_valid;
  assign quotient_data       = quot_q;
  assign quotient_data_valid = valid_q;
  assign busy                = busy_q;

  always_comb begin
    lane_idx     = '0;
    lane_dvd_bit = '0;
    lane_dvs     = '0;
    lane_qfull   = '0;
    lane_res     = '0;
    for (int unsigned j = 0; j < PAR_LANES; j++) begin
      lane_idx[j]     = IW'(g_q * PAR_LANES + j);
      lane_dvd_bit[j] = dvd_q[lane_idx[j]][b_q];
      lane_dvs[j]     = dvs_q[lane_idx[j]];
      lane_qfull[j]   = qacc_q[j] | DIVIDEND_WIDTH'(lane_q[j]);
      // A zero divisor is forced to all ones so the result is independent of the output width.
      lane_res[j]     = (lane_dvs[j] == '0) ? '1 : QUOTIENT_WIDTH'(lane_qfull[j]);
    end
  end

  for (genvar j = 0; j < PAR_LANES; j++) begin : g_lane
    int_div_restoring_step #(
      .DIVISOR_WIDTH(DIVISOR_WIDTH),
      .REM_W        (REM_W)
    ) u_step (
      .rem_i    (rem_q[j]),
      .dvd_bit_i(lane_dvd_bit[j]),
      .divisor_i(lane_dvs[j]),
      .rem_o    (lane_rem[j]),
      .q_bit_o  (lane_q[j])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qacc_q  <= '0;
      quot_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dividend_data_valid && divisor_data_valid) begin
            dvd_q   <= dividend_data;
            dvs_q   <= divisor_data;
            g_q     <= '0;
            b_q     <= B_FIRST;
            rem_q   <= '0;
            qacc_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          for (int unsigned j = 0; j < PAR_LANES; j++) begin
            rem_q[j]       <= lane_rem[j];
            qacc_q[j][b_q] <= lane_q[j];
          end
          if (b_q == '0) begin
            for (int unsigned j = 0; j < PAR_LANES; j++) begin
              quot_q[lane_idx[j]] <= lane_res[j];
              rem_q[j]            <= '0;
              qacc_q[j]           <= '0;
            end
            b_q <= B_FIRST;
            if (g_q == G_LAST) begin
              valid_q <= 1'b1;
              state_q <= OUT;
            end else begin
              g_q <= g_q + 1'b1;
            end
          end else begin
            b_q <= b_q - 1'b1;
          end
        end
        OUT: begin
          if (quotient_data_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_seq_ctrl.sv
// Scoreboard bench for int_div_seq_ctrl: directed scenarios on a default instance plus
// randomized regressions on narrow-quotient instances with 1, 2 and 8 lanes.
module tb_int_div_seq_ctrl;

  localparam int unsigned NVEC = 400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit go_rand = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected output", nm);
  endtask

  // Reference: plain unsigned floor division per element, zero divisor gives all ones.
  function automatic logic [7:0][7:0] ref_div(input logic [7:0][7:0] a, input logic [7:0][7:0] b);
    logic [7:0][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (b[i] == 8'd0) ? 8'hFF : 8'(a[i] / b[i]);
    return r;
  endfunction

  // ---------------- default instance (directed) ----------------
  logic [7:0][7:0] a_d = '0, b_d = '0, q_d;
  logic a_v = 1'b0, b_v = 1'b0, a_rdy, b_rdy, q_v, q_rdy = 1'b1, busy;
  logic [7:0][7:0] exp_q[$];

  int_div_seq_ctrl #(
    .IN_NUM(8), .DIVIDEND_WIDTH(8), .DIVISOR_WIDTH(8), .QUOTIENT_WIDTH(8), .PAR_LANES(2)
  ) u_dut (
    .clk(clk), .rst(rst),
    .dividend_data(a_d), .dividend_data_valid(a_v), .dividend_data_ready(a_rdy),
    .divisor_data(b_d), .divisor_data_valid(b_v), .divisor_data_ready(b_rdy),
    .quotient_data(q_d), .quotient_data_valid(q_v), .quotient_data_ready(q_rdy),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (rst && q_v) begin
      if (exp_q.size() == 0) fail_now("main_spurious");
      else begin
        chk("main_quotient", q_d, exp_q[0]);
        if (q_rdy) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0][7:0] a, input logic [7:0][7:0] b, input bit push, input bit meas);
    int unsigned t;
    @(negedge clk);
    a_d = a; b_d = b; a_v = 1'b1; b_v = 1'b1;
    if (push) exp_q.push_back(ref_div(a, b));
    #1;
    t = 0;
    while (!a_rdy && t < 200) begin @(negedge clk); #1; t++; end
    if (!a_rdy) fail_now("accept_timeout");
    @(posedge clk); #1;
    a_v = 1'b0; b_v = 1'b0;
    if (meas) begin
      t = 0;
      while (!q_v && t < 100) begin @(posedge clk); #1; t++; end
      chk("latency", 64'(t), 64'd32);
    end
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- randomized narrow-quotient instances ----------------
  for (genvar c = 0; c < 3; c++) begin : g_rand
    localparam int unsigned PL = (c == 0) ? 1 : (c == 1) ? 2 : 8;
    logic [7:0][7:0] ra = '0, rb = '0;
    logic [7:0][3:0] rq;
    logic rav = 1'b0, rbv = 1'b0, rar, rbr, rqv, rqr = 1'b0, rbusy;
    logic [7:0][3:0] rexp[$];
    int unsigned n_out = 0;
    bit done = 1'b0;

    int_div_seq_ctrl #(
      .IN_NUM(8), .DIVIDEND_WIDTH(8), .DIVISOR_WIDTH(8), .QUOTIENT_WIDTH(4), .PAR_LANES(PL)
    ) u_dut (
      .clk(clk), .rst(rst),
      .dividend_data(ra), .dividend_data_valid(rav), .dividend_data_ready(rar),
      .divisor_data(rb), .divisor_data_valid(rbv), .divisor_data_ready(rbr),
      .quotient_data(rq), .quotient_data_valid(rqv), .quotient_data_ready(rqr),
      .busy(rbusy)
    );

    always @(negedge clk) begin
      rqr = ($urandom_range(0, 3) != 0);
      if (rst && rqv) begin
        if (rexp.size() == 0) fail_now($sformatf("rand_pl%0d_spurious", PL));
        else begin
          chk($sformatf("rand_pl%0d_quotient", PL), 64'(rq), 64'(rexp[0]));
          if (rqr) begin void'(rexp.pop_front()); n_out++; end
        end
      end
    end

    initial begin : drv
      logic [7:0][7:0] va, vb, full;
      logic [7:0][3:0] e;
      int unsigned t;
      wait (go_rand);
      for (int n = 0; n < int'(NVEC); n++) begin
        for (int i = 0; i < 8; i++) begin
          va[i] = 8'($urandom);
          vb[i] = 8'($urandom) >> $urandom_range(0, 7);
        end
        full = ref_div(va, vb);
        for (int i = 0; i < 8; i++) e[i] = full[i][3:0];
        rexp.push_back(e);
        @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ra = va; rb = vb;
        if ($urandom_range(0, 1) != 0) rav = 1'b1; else rbv = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rav = 1'b1; rbv = 1'b1;
        #1;
        t = 0;
        while (!rar && t < 500) begin @(negedge clk); #1; t++; end
        if (!rar) fail_now($sformatf("rand_pl%0d_accept", PL));
        @(posedge clk); #1;
        rav = 1'b0; rbv = 1'b0;
      end
      t = 0;
      while (rexp.size() != 0 && t < 2000) begin @(posedge clk); t++; end
      chk($sformatf("rand_pl%0d_count", PL), 64'(n_out), 64'(NVEC));
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [7:0][7:0] va, vb;
    int unsigned t;

    #1;
    chk("rst_valid", 64'(q_v), 64'd0);
    chk("rst_quotient", q_d, 64'd0);
    chk("rst_dvd_ready", 64'(a_rdy), 64'd0);
    chk("rst_dvs_ready", 64'(b_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Spec vector: element i listed in order 0..7.
    va[0] = 8'd200; va[1] = 8'd255; va[2] = 8'd7; va[3] = 8'd0;
    va[4] = 8'd100; va[5] = 8'd9;   va[6] = 8'd81; va[7] = 8'd128;
    vb[0] = 8'd10;  vb[1] = 8'd1;   vb[2] = 8'd7; vb[3] = 8'd5;
    vb[4] = 8'd3;   vb[5] = 8'd2;   vb[6] = 8'd9; vb[7] = 8'd128;
    send(va, vb, 1'b1, 1'b1);
    drain();
    chk("spec_e0", 64'(q_d[0]), 64'd20);
    chk("spec_e4", 64'(q_d[4]), 64'd33);

    // Reset mid-calculation aborts the vector; readies stay low even with both valids up.
    for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom_range(1, 255)); end
    send(va, vb, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    a_v = 1'b1; b_v = 1'b1; rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(q_v), 64'd0);
    chk("midrst_dvd_ready", 64'(a_rdy), 64'd0);
    chk("midrst_dvs_ready", 64'(b_rdy), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_quotient", q_d, 64'd0);
    @(negedge clk); a_v = 1'b0; b_v = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Zero divisor on one element, neighbours random.
    for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom_range(1, 40)); end
    va[3] = 8'd77; vb[3] = 8'd0;
    send(va, vb, 1'b1, 1'b1);
    drain();
    chk("divzero_e3", 64'(q_d[3]), 64'hFF);
    chk("divzero_e2", 64'(q_d[2]), 64'(va[2] / vb[2]));

    // Dividend valid alone is never consumed.
    for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
    @(negedge clk);
    a_d = va; a_v = 1'b1; b_v = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("alone_dvd_ready", 64'(a_rdy), 64'd0);
      chk("alone_dvs_ready", 64'(b_rdy), 64'd1);
      chk("alone_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end
    b_d = vb; b_v = 1'b1;
    exp_q.push_back(ref_div(va, vb));
    #1;
    chk("join_dvd_ready", 64'(a_rdy), 64'd1);
    chk("join_dvs_ready", 64'(b_rdy), 64'd1);
    @(posedge clk); #1;
    a_v = 1'b0; b_v = 1'b0;
    chk("join_busy", 64'(busy), 64'd1);
    chk("join_ready_drop", 64'({a_rdy, b_rdy}), 64'd0);
    drain();

    // Backpressure in OUT with a new vector already offered.
    q_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom) >> $urandom_range(0, 7); end
    send(va, vb, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom_range(1, 255)); end
    @(negedge clk);
    a_d = va; b_d = vb; a_v = 1'b1; b_v = 1'b1;
    exp_q.push_back(ref_div(va, vb));
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("hold_valid", 64'(q_v), 64'd1);
      chk("hold_readies", 64'({a_rdy, b_rdy}), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    q_rdy = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 64'(q_v), 64'd0);
    chk("release_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("reaccept_busy", 64'(busy), 64'd1);
    a_v = 1'b0; b_v = 1'b0;
    drain();

    go_rand = 1'b1;
    t = 0;
    while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && t < 80000) begin
      @(posedge clk); t++;
    end
    if (!(g_rand[0].done && g_rand[1].done && g_rand[2].done)) fail_now("rand_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
